mor1kx_icache_refill_ctrl: RTL
==============================

// Module: mor1kx_icache_refill_ctrl
// PURPOSE
//  Sequences instruction-cache line refills. Detects the cache's refill request,
//  issues a wrapping burst on the instruction bus, and streams returned words into
//  the cache write port (wradr/wrdat/we). Reports bus errors and timeouts as a
//  one-cycle error pulse. Sits between the icache and the ibus bridge.
// PARAMETERS
//  OPTION_OPERAND_WIDTH       32  address/data width
//  OPTION_ICACHE_BLOCK_WIDTH   5  log2 line bytes (4 => 16 B, 5 => 32 B); WORDS = 2^(BW-2)
//  TIMEOUT_WIDTH               8  ack-wait counter width; timeout at 2^TW-1 idle cycles
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  cpu_adr_i      in   32  miss (fetch-match) address, valid while refill_req_i
//  refill_req_i   in   1   cache refill request (stays high through cache REFILL)
//  wradr_o        out  32  cache write address
//  wrdat_o        out  32  cache write data
//  we_o           out  1   cache write strobe, one per beat
//  err_o          out  1   one-cycle pulse: bus error/timeout; drives ic_imem_err_i
//  busy_o         out  1   high in any state other than IDLE
//  ibus_adr_o     out  32  bus beat address
//  ibus_req_o     out  1   bus request, held until last ack
//  ibus_burst_o   out  1   burst in progress (high with req except final beat)
//  ibus_last_o    out  1   current beat is the final beat of the line
//  ibus_ack_i     in   1   beat accepted; ibus_dat_i valid
//  ibus_err_i     in   1   beat error
//  ibus_dat_i     in   32  beat read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; beat counter and timeout counter 0.
//  States: IDLE -> BURST -> DRAIN -> IDLE.
//  IDLE: refill_req_i=1 -> capture start address, ibus_req_o=1 next cycle, go BURST.
//   Line base = cpu_adr_i[31:BW], low bits 0.
//  BURST: on ibus_ack_i & !ibus_err_i, next cycle: we_o=1, wradr_o = acked address,
//   wrdat_o = ibus_dat_i (registered, 1-cycle latency). Address advances +4 modulo
//   line: {base, (off+4) mod 2^BW}. Beat counter increments. ibus_last_o=1 when
//   count==WORDS-1; ibus_burst_o = ibus_req_o & !ibus_last_o. After the last ack,
//   req/burst/last drop next cycle; go DRAIN.
//  Timeout: counter increments each BURST cycle without ack, clears on ack;
//   reaching 2^TW-1 = error.
//  Error (ibus_err_i, or timeout): err_o=1 for exactly one cycle, no we_o for that
//   beat, req dropped next cycle, go DRAIN. ack and err together: err wins.
//  DRAIN: wait until refill_req_i=0 (cache left REFILL), then IDLE; prevents retrigger
//   on the stale request.
//  we_o never asserted outside BURST/DRAIN-entry; exactly WORDS pulses per good refill.
//  Synchronous reset mid-burst: next edge returns to IDLE, all outputs 0, no further
//   we_o; pending bus beat is abandoned.
//  No refill_req_i while busy is accepted; a new request is only sampled in IDLE.
// CONFIGURATION
//  ICACHE_REFILL_CWF_EN defined: critical-word-first; start address = {base,
//   cpu_adr_i[BW-1:2],2'b00}, burst wraps around the line.
//  Undefined: start address = line base; linear burst, no wrap needed.
//  Beat count, last flag and error handling identical in both builds.
// TESTING
//  CWF_EN, BW=5, miss 0x0000_1014, zero-wait acks -> ibus_adr 0x1014,0x1018,0x101C,
//   0x1000..0x1010; 8 we_o with matching wradr; last on 8th; busy_o low after req drops.
//  No CWF_EN, same miss -> addresses 0x1000..0x101C in order; 8 we_o; wrdat equals beat data.
//  Random 0-5 wait states per beat -> identical address/data order; exactly 8 we_o; no gaps lost.
//  ibus_err_i with 3rd ack -> 2 we_o, err_o single pulse, req_o 0 next cycle, IDLE once
//   refill_req_i falls.
//  Ack withheld 255 cycles (TW=8) -> err_o pulse on expiry, no we_o; rst pulse mid-burst
//   (beat 4) -> all outputs 0 next cycle.
//  Back-to-back misses 0x2000 then 0x3008: second burst starts only after refill_req_i
//   low then high again.

Source files
------------

// File: rtl/mor1kx_icache_refill_ctrl.sv
// rtl/mor1kx_icache_refill_ctrl.sv - icache line refill sequencer (burst on ibus, stream into cache write port)
// Optional build macro: ICACHE_REFILL_CWF_EN (critical-word-first wrapping burst).
module mor1kx_icache_refill_ctrl #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
    parameter int TIMEOUT_WIDTH             = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_i,
    input  logic                            refill_req_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            err_o,
    output logic                            busy_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
    output logic                            ibus_req_o,
    output logic                            ibus_burst_o,
    output logic                            ibus_last_o,
    input  logic                            ibus_ack_i,
    input  logic                            ibus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int TW = TIMEOUT_WIDTH;
    localparam int CW = BW - 2;

    // Masking the full miss address keeps every input bit in use in both builds.
`ifdef ICACHE_REFILL_CWF_EN
    localparam logic [OW-1:0] START_MASK = {{(OW-2){1'b1}}, 2'b00};
`else
    localparam logic [OW-1:0] START_MASK = {{(OW-BW){1'b1}}, {BW{1'b0}}};
`endif
    localparam logic [TW-1:0] TMO_LAST = {{(TW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [OW-1:0]   r_adr;
    logic [OW-1:0]   r_wradr;
    logic [OW-1:0]   r_wrdat;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_we;
    logic            r_err;
    logic            w_req;
    logic            w_last;
    logic            w_tmo_hit;
    logic            w_fail;
    logic            w_good;
    logic [OW-1:0]   w_adr_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (refill_req_i) w_next = S_BURST;
            S_BURST: if (w_fail || (w_good && w_last)) w_next = S_DRAIN;
            S_DRAIN: if (!refill_req_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req     = (r_state == S_BURST);
        w_last    = w_req && (&r_cnt);
        w_tmo_hit = w_req && !ibus_ack_i && (r_tmo == TMO_LAST);
        // A beat error beats a simultaneous ack.
        w_fail    = w_req && (ibus_err_i || w_tmo_hit);
        w_good    = w_req && ibus_ack_i && !ibus_err_i;
    end

    assign w_adr_next   = {r_adr[OW-1:BW], r_adr[BW-1:0] + BW'(4)};
    assign ibus_req_o   = w_req;
    assign ibus_last_o  = w_last;
    assign ibus_burst_o = w_req && !w_last;
    assign ibus_adr_o   = r_adr;
    assign busy_o       = (r_state != S_IDLE);
    assign we_o         = r_we;
    assign err_o        = r_err;
    assign wradr_o      = r_wradr;
    assign wrdat_o      = r_wrdat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr   <= '0;
            r_wradr <= '0;
            r_wrdat <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (r_state == S_IDLE && refill_req_i) begin
                r_adr <= cpu_adr_i & START_MASK;
                r_cnt <= '0;
                r_tmo <= '0;
            end else if (w_fail) begin
                r_err <= 1'b1;
            end else if (w_good) begin
                r_we    <= 1'b1;
                r_wradr <= r_adr;
                r_wrdat <= ibus_dat_i;
                r_adr   <= w_adr_next;
                r_cnt   <= r_cnt + CW'(1);
                r_tmo   <= '0;
            end else if (w_req) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end
endmodule
